core_mem: RTL

- Memory-access pipeline stage. Consumes the EX/MEM register produced by the execute stage and drives the data-bus master port.
- Produces the MEM/WB register for writeback, plus the forwarding/hazard signals the execute-stage bypass logic reads (mw_rd, mw_reg_write, mw_csr, mw_csr_write, mw_reg_write_data, mw_csr_data, mw_mem_read_data_valid).
- Non-memory instructions pass through in one cycle. Loads and stores run a bus handshake under a small FSM.

---
 rtl/core_mem_pkg.sv | 31 +++
 rtl/core_mem_align.sv | 51 +++++
 rtl/core_mem.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
// Shared definitions for the memory-access stage.
//   MEM_OP_*        : funct3 encodings of the load/store width
//   mem_state_e     : bus handshake FSM states
//   mem_misaligned  : natural-alignment check for a given width and addr[1:0]
package core_mem_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

    function automatic logic mem_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_OP_H, MEM_OP_HU: mis = addr_lo[0];
            MEM_OP_W:            mis = (addr_lo != 2'b00);
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane logic for a 32-bit data bus (combinational).
//   op, addr_lo : access width (funct3) and byte offset within the word
//   sdata       : store data, low bits significant
//   rdata       : raw bus read word
//   wstrb/wdata : byte enables and lane-replicated store data
//   ldata       : load result, shifted down and sign/zero extended
module core_mem_align
    import core_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    always_comb begin
        wstrb = 4'hF;
        wdata = sdata;
        case (op)
            MEM_OP_B: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_OP_H: begin
                // addr_lo[0] deliberately ignored: the half lane is picked by addr[1] only
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lbyte = rdata[{addr_lo, 3'b000} +: 8];
        lhalf = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (op)
            MEM_OP_B:  ldata = {{24{lbyte[7]}}, lbyte};
            MEM_OP_H:  ldata = {{16{lhalf[15]}}, lhalf};
            MEM_OP_BU: ldata = {24'h0, lbyte};
            MEM_OP_HU: ldata = {16'h0, lhalf};
            default:   ldata = rdata;
        endcase
    end

endmodule

// File: rtl/core_mem.sv
// Memory-access pipeline stage: EX/MEM in, data-bus master, MEM/WB out.
//   em_*  : EX/MEM entry (valid/ready handshake)
//   bus_* : data-bus request/response; request fields are zero outside S_REQ
//   mw_*  : MEM/WB entry plus the bypass/hazard view of the held entry
// Non-memory entries pass in one cycle; loads/stores run the S_REQ/S_RSP/S_DONE FSM.
// Optional: define CORE_MEM_MISALIGN_CHECK_EN to add misalign_valid/misalign_addr
// and skip the bus for misaligned half/word accesses.
module core_mem
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              em_valid,
    output logic              em_ready,
    input  logic [XLEN-1:0]   em_reg_data_mem_addr,
    input  logic [XLEN-1:0]   em_csr_data_mem_data,
    input  logic              em_mem_read,
    input  logic              em_mem_write,
    input  logic [2:0]        em_mem_op,
    input  logic [4:0]        em_rd,
    input  logic              em_reg_write,
    input  logic [11:0]       em_csr,
    input  logic              em_csr_write,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              mw_valid,
    input  logic              mw_ready,
    output logic [XLEN-1:0]   mw_reg_write_data,
    output logic [XLEN-1:0]   mw_csr_data,
    output logic [4:0]        mw_rd,
    output logic              mw_reg_write,
    output logic [11:0]       mw_csr,
    output logic              mw_csr_write,
    output logic              mw_mem_read_data_valid
`ifdef CORE_MEM_MISALIGN_CHECK_EN
    ,
    output logic              misalign_valid,
    output logic [ADDR_W-1:0] misalign_addr
`endif
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic              we_q, we_d;
    logic              mw_valid_q, mw_valid_d;
    logic              mw_rdv_q, mw_rdv_d;
    logic [XLEN-1:0]   mw_data_q, mw_data_d;
    logic [XLEN-1:0]   mw_csr_data_q, mw_csr_data_d;
    logic [4:0]        mw_rd_q, mw_rd_d;
    logic              mw_reg_write_q, mw_reg_write_d;
    logic [11:0]       mw_csr_q, mw_csr_d;
    logic              mw_csr_write_q, mw_csr_write_d;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
    logic              mis_valid_q, mis_valid_d;
    logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;
`endif

    logic              accept;
    logic              is_mem;
    logic              skip_bus;
    logic [3:0]        al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ldata;

    core_mem_align u_align (
        .op      (op_q),
        .addr_lo (addr_q[1:0]),
        .sdata   (sdata_q),
        .rdata   (bus_rdata),
        .wstrb   (al_wstrb),
        .wdata   (al_wdata),
        .ldata   (al_ldata)
    );

    assign em_ready = (state_q == S_IDLE) && (!mw_valid_q || mw_ready);
    assign accept   = em_valid && em_ready;
    assign is_mem   = em_mem_read || em_mem_write;

`ifdef CORE_MEM_MISALIGN_CHECK_EN
    assign skip_bus = mem_misaligned(em_mem_op, em_reg_data_mem_addr[1:0]);
`else
    assign skip_bus = 1'b0;
`endif

    // Request fields are masked outside S_REQ so reset/idle shows an all-zero bus.
    assign bus_req_valid = (state_q == S_REQ);
    assign bus_addr      = bus_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_we        = bus_req_valid && we_q;
    assign bus_wstrb     = (bus_req_valid && we_q) ? al_wstrb : 4'h0;
    assign bus_wdata     = (bus_req_valid && we_q) ? al_wdata : '0;

    assign mw_valid               = mw_valid_q;
    assign mw_mem_read_data_valid = mw_rdv_q;
    assign mw_reg_write_data      = mw_data_q;
    assign mw_csr_data            = mw_csr_data_q;
    assign mw_rd                  = mw_rd_q;
    assign mw_reg_write           = mw_reg_write_q;
    assign mw_csr                 = mw_csr_q;
    assign mw_csr_write           = mw_csr_write_q;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
    assign misalign_valid = mis_valid_q;
    assign misalign_addr  = mis_addr_q;
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        op_d           = op_q;
        sdata_d        = sdata_q;
        we_d           = we_q;
        mw_valid_d     = mw_valid_q;
        mw_rdv_d       = mw_rdv_q;
        mw_data_d      = mw_data_q;
        mw_csr_data_d  = mw_csr_data_q;
        mw_rd_d        = mw_rd_q;
        mw_reg_write_d = mw_reg_write_q;
        mw_csr_d       = mw_csr_q;
        mw_csr_write_d = mw_csr_write_q;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
        mis_valid_d    = 1'b0;
        mis_addr_d     = mis_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mw_valid_q && mw_ready) begin
                    mw_valid_d = 1'b0;
                    mw_rdv_d   = 1'b0;
                end
                if (accept) begin
                    mw_rd_d        = em_rd;
                    mw_csr_d       = em_csr;
                    mw_csr_write_d = em_csr_write;
                    mw_csr_data_d  = em_csr_data_mem_data;
                    if (!is_mem) begin
                        mw_valid_d     = 1'b1;
                        mw_rdv_d       = 1'b1;
                        mw_data_d      = em_reg_data_mem_addr;
                        mw_reg_write_d = em_reg_write;
                    end else begin
                        // rd/reg_write become visible now so the bypass can stall on them
                        mw_valid_d     = 1'b0;
                        mw_rdv_d       = 1'b0;
                        mw_data_d      = '0;
                        mw_reg_write_d = em_reg_write && em_mem_read;
                        addr_d         = em_reg_data_mem_addr[ADDR_W-1:0];
                        op_d           = em_mem_op;
                        sdata_d        = em_csr_data_mem_data;
                        we_d           = !em_mem_read;   // read wins when both are set
                        state_d        = S_REQ;
                        if (skip_bus) begin
                            state_d        = S_DONE;
                            mw_valid_d     = 1'b1;
                            mw_rdv_d       = 1'b1;
                            mw_reg_write_d = 1'b0;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
                            mis_valid_d    = 1'b1;
                            mis_addr_d     = em_reg_data_mem_addr[ADDR_W-1:0];
`endif
                        end
                    end
                end
            end
            S_REQ: begin
                if (bus_req_ready) begin
                    if (we_q) begin
                        // posted write: no response, complete immediately
                        state_d    = S_DONE;
                        mw_valid_d = 1'b1;
                        mw_rdv_d   = 1'b1;
                    end else begin
                        state_d = S_RSP;
                    end
                end
            end
            S_RSP: begin
                if (bus_rsp_valid) begin
                    state_d    = S_DONE;
                    mw_data_d  = al_ldata;
                    mw_valid_d = 1'b1;
                    mw_rdv_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (mw_ready) begin
                    state_d    = S_IDLE;
                    mw_valid_d = 1'b0;
                    mw_rdv_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            op_q           <= '0;
            sdata_q        <= '0;
            we_q           <= 1'b0;
            mw_valid_q     <= 1'b0;
            mw_rdv_q       <= 1'b0;
            mw_data_q      <= '0;
            mw_csr_data_q  <= '0;
            mw_rd_q        <= '0;
            mw_reg_write_q <= 1'b0;
            mw_csr_q       <= '0;
            mw_csr_write_q <= 1'b0;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
            mis_valid_q    <= 1'b0;
            mis_addr_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            op_q           <= op_d;
            sdata_q        <= sdata_d;
            we_q           <= we_d;
            mw_valid_q     <= mw_valid_d;
            mw_rdv_q       <= mw_rdv_d;
            mw_data_q      <= mw_data_d;
            mw_csr_data_q  <= mw_csr_data_d;
            mw_rd_q        <= mw_rd_d;
            mw_reg_write_q <= mw_reg_write_d;
            mw_csr_q       <= mw_csr_d;
            mw_csr_write_q <= mw_csr_write_d;
`ifdef CORE_MEM_MISALIGN_CHECK_EN
            mis_valid_q    <= mis_valid_d;
            mis_addr_q     <= mis_addr_d;
`endif
        end
    end

endmodule
